gb_gain_apply: RTL and testbench

//  Gray-balance correction stage. Multiplies each R/G/B pixel by a per-channel fixed-point gain,

---
 rtl/gb_pkg.sv | 21 ++
 rtl/gb_mul_sat.sv | 56 +++++
 rtl/gb_gain_apply.sv | 156 +++++++++++++++
 tb/tb_gb_gain_apply.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_pkg.sv
// Shared definitions for the gray-balance gain stage: frame FSM encoding,
// channel slice positions and the unity-gain helper.
package gb_pkg;

  typedef enum logic {
    GB_FSM_IDLE   = 1'b0,
    GB_FSM_ACTIVE = 1'b1
  } gb_fsm_e;

  // Channel slice indices within a packed {R,G,B} word (R in the MSBs)
  localparam int unsigned GB_CH_R   = 2;
  localparam int unsigned GB_CH_G   = 1;
  localparam int unsigned GB_CH_B   = 0;
  localparam int unsigned GB_NUM_CH = 3;

  // Fixed-point 1.0 for a gain with 'frac' fractional bits
  function automatic int unsigned gb_unity_gain(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

endpackage

// File: rtl/gb_mul_sat.sv
// One colour channel of the gain datapath: S2 multiply, S3 round and saturate.
// Advances only when en is high; bypass selects the original sample at S3.
module gb_mul_sat #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GAIN_WIDTH = 12,
  parameter int unsigned GAIN_FRAC  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [GAIN_WIDTH-1:0] g,
  input  logic                  bypass,
  output logic [DATA_WIDTH-1:0] y
);

  localparam int unsigned PW = DATA_WIDTH + GAIN_WIDTH;
  localparam logic [PW:0] HALF = {{PW{1'b0}}, 1'b1} << (GAIN_FRAC - 1);

  logic [PW-1:0]         prod;
  logic [DATA_WIDTH-1:0] x_q;
  logic                  byp_q;
  logic [PW:0]           rnd;
  logic [PW:0]           shifted;
  logic [DATA_WIDTH-1:0] sat;

  // S2: full-precision product, raw sample and bypass flag travel alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod  <= '0;
      x_q   <= '0;
      byp_q <= 1'b0;
    end else if (en) begin
      prod  <= {{GAIN_WIDTH{1'b0}}, x} * {{DATA_WIDTH{1'b0}}, g};
      x_q   <= x;
      byp_q <= bypass;
    end
  end

  // Round half up, drop the fraction, clamp to full scale
  always_comb begin
    rnd     = {1'b0, prod} + HALF;
    shifted = rnd >> GAIN_FRAC;
    sat     = (|shifted[PW:DATA_WIDTH]) ? '1 : shifted[DATA_WIDTH-1:0];
  end

  // S3: registered channel output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (en) begin
      y <= byp_q ? x_q : sat;
    end
  end

endmodule

// File: rtl/gb_gain_apply.sv
// Gray-balance correction stage: per-channel fixed-point gain with rounding
// and saturation, double-buffered gains swapped only at frame start, and a
// frame-framing checker. Three-stage pipe frozen whenever dout_ready is low.
module gb_gain_apply
  import gb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GAIN_WIDTH = 12,
  parameter int unsigned GAIN_FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3*DATA_WIDTH-1:0] din,
  input  logic                    din_valid,
  input  logic                    din_sop,
  input  logic                    din_eop,
  output logic                    din_ready,
  input  logic [GAIN_WIDTH-1:0]   gain_r,
  input  logic [GAIN_WIDTH-1:0]   gain_g,
  input  logic [GAIN_WIDTH-1:0]   gain_b,
  input  logic                    gain_load,
  input  logic                    bypass,
  output logic [3*DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  output logic                    dout_sop,
  output logic                    dout_eop,
  input  logic                    dout_ready,
  output logic                    frame_err
);

  localparam int unsigned GW3 = GB_NUM_CH * GAIN_WIDTH;
  localparam int unsigned DW3 = GB_NUM_CH * DATA_WIDTH;
  localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(gb_unity_gain(GAIN_FRAC));

  logic           adv;
  logic           acc;
  logic           swap;
  logic [GW3-1:0] gain_in;
  logic [GW3-1:0] shadow;
  logic [GW3-1:0] active;
  logic [GW3-1:0] sel_gain;
  logic           pend;
  gb_fsm_e        state;

  logic           s1_valid, s1_sop, s1_eop, s1_byp;
  logic [DW3-1:0] s1_px;
  logic [GW3-1:0] s1_gain;
  logic           s2_valid, s2_sop, s2_eop;

  assign adv       = dout_ready;
  assign din_ready = dout_ready;
  assign acc       = din_valid & dout_ready;
  // A sop with a pending set swaps and uses the new gains on that same pixel
  assign swap      = acc & din_sop & pend;
  assign sel_gain  = swap ? shadow : active;

  // Pack incoming gains in the same channel order as the pixel word
  always_comb begin
    gain_in = '0;
    gain_in[GB_CH_R*GAIN_WIDTH +: GAIN_WIDTH] = gain_r;
    gain_in[GB_CH_G*GAIN_WIDTH +: GAIN_WIDTH] = gain_g;
    gain_in[GB_CH_B*GAIN_WIDTH +: GAIN_WIDTH] = gain_b;
  end

  // Gain double-buffer: a load landing with a swapping sop stays pending for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= {GB_NUM_CH{UNITY}};
      active <= {GB_NUM_CH{UNITY}};
      pend   <= 1'b0;
    end else begin
      if (swap)      active <= shadow;
      if (gain_load) shadow <= gain_in;
      if (gain_load) pend <= 1'b1;
      else if (swap) pend <= 1'b0;
    end
  end

  // Frame tracker with sticky framing error, stepped by accepted pixels only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= GB_FSM_IDLE;
      frame_err <= 1'b0;
    end else if (acc) begin
      case (state)
        GB_FSM_IDLE: begin
          if (din_sop) begin
            state <= din_eop ? GB_FSM_IDLE : GB_FSM_ACTIVE;
          end else if (din_eop) begin
            frame_err <= 1'b1;
          end
        end
        GB_FSM_ACTIVE: begin
          if (din_sop) frame_err <= 1'b1;
          state <= din_eop ? GB_FSM_IDLE : GB_FSM_ACTIVE;
        end
        default: state <= GB_FSM_IDLE;
      endcase
    end
  end

  // S1: capture pixel, markers and the gain set it will use
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_byp   <= 1'b0;
      s1_px    <= '0;
      s1_gain  <= '0;
    end else if (adv) begin
      s1_valid <= din_valid;
      s1_sop   <= din_valid & din_sop;
      s1_eop   <= din_valid & din_eop;
      s1_byp   <= bypass;
      s1_px    <= din;
      s1_gain  <= sel_gain;
    end
  end

  // S2/S3 control: valid and frame markers follow the datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_sop     <= 1'b0;
      s2_eop     <= 1'b0;
      dout_valid <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_sop     <= s1_sop;
      s2_eop     <= s1_eop;
      dout_valid <= s2_valid;
      dout_sop   <= s2_sop;
      dout_eop   <= s2_eop;
    end
  end

  for (genvar c = 0; c < GB_NUM_CH; c++) begin : g_ch
    gb_mul_sat #(
      .DATA_WIDTH(DATA_WIDTH),
      .GAIN_WIDTH(GAIN_WIDTH),
      .GAIN_FRAC (GAIN_FRAC)
    ) u_mul_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (adv),
      .x     (s1_px[c*DATA_WIDTH +: DATA_WIDTH]),
      .g     (s1_gain[c*GAIN_WIDTH +: GAIN_WIDTH]),
      .bypass(s1_byp),
      .y     (dout[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_gb_gain_apply.sv
// Bench for gb_gain_apply: gain/rounding table, frame sequences, double-buffer
// timing, random back-pressure with a scoreboard, framing errors and reset.
module tb_gb_gain_apply;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] din = '0;
  logic        din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic        din_ready;
  logic [11:0] gain_r = 12'd256, gain_g = 12'd256, gain_b = 12'd256;
  logic        gain_load = 1'b0, bypass = 1'b0;
  logic [23:0] dout;
  logic        dout_valid, dout_sop, dout_eop;
  logic        dout_ready = 1'b1;
  logic        frame_err;

  gb_gain_apply #(.DATA_WIDTH(8), .GAIN_WIDTH(12), .GAIN_FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_sop(din_sop),
    .din_eop(din_eop), .din_ready(din_ready), .gain_r(gain_r), .gain_g(gain_g),
    .gain_b(gain_b), .gain_load(gain_load), .bypass(bypass), .dout(dout),
    .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_ready(dout_ready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] data; logic sop; logic eop; } exp_t;
  exp_t q[$];

  typedef struct {
    logic [11:0] gr, gg, gb;
    logic [23:0] px;
    logic        byp;
    logic [23:0] exp_px;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [11:0] m_sh[3];
  logic [11:0] m_act[3];
  bit          m_pend, m_active, m_err;

  logic [23:0] last_out = '0;
  bit          held = 0;
  logic [25:0] held_val;
  bit          rand_rdy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] chan(input logic [7:0] x, input logic [11:0] g, input bit byp);
    int unsigned r;
    r = (int'(x) * int'(g) + 128) >> 8;
    if (byp) return x;
    return (r > 255) ? 8'd255 : r[7:0];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_sh[c]  = 12'd256;
      m_act[c] = 12'd256;
    end
    m_pend = 0; m_active = 0; m_err = 0;
    q.delete();
    held = 0;
  endtask

  // Model step for a pixel accepted at the coming edge; index 2=R,1=G,0=B
  task automatic model_accept();
    logic [11:0] g[3];
    logic [7:0]  x;
    exp_t e;
    for (int c = 0; c < 3; c++) g[c] = (din_sop && m_pend) ? m_sh[c] : m_act[c];
    if (din_sop && m_pend) begin
      for (int c = 0; c < 3; c++) m_act[c] = m_sh[c];
      m_pend = 0;
    end
    if (!m_active) begin
      if (din_sop) m_active = !din_eop;
      else if (din_eop) m_err = 1;
    end else begin
      if (din_sop) m_err = 1;
      m_active = !din_eop;
    end
    for (int c = 0; c < 3; c++) begin
      x = din[c*8 +: 8];
      e.data[c*8 +: 8] = chan(x, g[c], bypass);
    end
    e.sop = din_sop;
    e.eop = din_eop;
    q.push_back(e);
  endtask

  // Monitor and model, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      exp_t e;
      if (held) check("stall_hold", {5'd0, dout_valid, dout_sop, dout_eop, dout}, {5'd0, 1'b1, held_val});
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("dout", {8'd0, dout}, {8'd0, e.data});
          check("dout_sop_eop", {30'd0, dout_sop, dout_eop}, {30'd0, e.sop, e.eop});
          last_out = dout;
        end
      end
      held = dout_valid && !dout_ready;
      held_val = {dout_sop, dout_eop, dout};
      if (din_valid && dout_ready) model_accept();
      if (gain_load) begin
        m_sh[2] = gain_r; m_sh[1] = gain_g; m_sh[0] = gain_b;
        m_pend = 1;
      end
    end
  end

  // Random back-pressure
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) dout_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic send(input logic [23:0] px, input bit sop, input bit eop, input bit byp, input bit ld);
    bit a = 0;
    din = px; din_sop = sop; din_eop = eop; bypass = byp; din_valid = 1'b1;
    gain_load = ld;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); a = dout_ready;
      @(posedge clk); #1;
      gain_load = 1'b0;
      if (a) break;
    end
    if (!a) check("send_timeout", 0, 1);
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0; bypass = 1'b0;
  endtask

  task automatic load(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b);
    gain_r = r; gain_g = g; gain_b = b; gain_load = 1'b1;
    @(posedge clk); #1;
    gain_load = 1'b0;
  endtask

  task automatic drain();
    rand_rdy = 0;
    dout_ready = 1'b1;
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_dout_valid", {31'd0, dout_valid}, 0);
    @(negedge clk);
    check("rst_dout_valid_next", {31'd0, dout_valid}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t tbl[6];

  initial begin
    int lat;
    model_reset();
    tbl[0] = '{12'd512,  12'd384,  12'd0,    {8'd200, 8'd101, 8'd50},  1'b0, {8'd255, 8'd152, 8'd0}};
    tbl[1] = '{12'd256,  12'd256,  12'd256,  {8'd10,  8'd20,  8'd30},  1'b0, {8'd10,  8'd20,  8'd30}};
    tbl[2] = '{12'd128,  12'd128,  12'd128,  {8'd100, 8'd1,   8'd255}, 1'b0, {8'd50,  8'd1,   8'd128}};
    tbl[3] = '{12'd4095, 12'd4095, 12'd4095, {8'd255, 8'd1,   8'd0},   1'b0, {8'd255, 8'd16,  8'd0}};
    tbl[4] = '{12'd512,  12'd0,    12'd300,  {8'd200, 8'd200, 8'd200}, 1'b1, {8'd200, 8'd200, 8'd200}};
    tbl[5] = '{12'd300,  12'd257,  12'd255,  {8'd255, 8'd127, 8'd128}, 1'b0, {8'd255, 8'd127, 8'd128}};

    // Reset state
    #2;
    check("reset_dout", {8'd0, dout}, 0);
    check("reset_flags", {28'd0, dout_valid, dout_sop, dout_eop, frame_err}, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: unity frame with latency check on the first pixel
    send({8'd10, 8'd20, 8'd30}, 1, 0, 0, 0);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!dout_valid && lat < 10);
    check("latency", lat, 3);
    @(posedge clk); #1;
    for (int k = 1; k < 8; k++) send({8'(10 + k), 8'(20 + k), 8'(30 + k)}, 0, k == 7, 0, 0);
    drain();
    check("unity_last", {8'd0, last_out}, {8'd0, 8'd17, 8'd27, 8'd37});

    // 2: gain / rounding / saturation table, one single-pixel frame each
    foreach (tbl[i]) begin
      load(tbl[i].gr, tbl[i].gg, tbl[i].gb);
      send(tbl[i].px, 1, 1, tbl[i].byp, 0);
      drain();
      check($sformatf("table_%0d", i), {8'd0, last_out}, {8'd0, tbl[i].exp_px});
    end

    // 3: double-buffer timing
    load(256, 256, 256);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) load(128, 256, 256);
      send({8'd100, 8'd80, 8'd60}, k == 0, k == 5, 0, 0);
    end
    drain();
    check("midload_unchanged", {8'd0, last_out}, {8'd0, 8'd100, 8'd80, 8'd60});
    send({8'd100, 8'd80, 8'd60}, 1, 0, 0, 0);
    send({8'd100, 8'd80, 8'd60}, 0, 1, 0, 0);
    drain();
    check("next_frame_r_half", {8'd0, last_out}, {8'd0, 8'd50, 8'd80, 8'd60});
    gain_r = 512; gain_g = 256; gain_b = 256;
    send({8'd100, 8'd80, 8'd60}, 1, 0, 0, 1);
    send({8'd100, 8'd80, 8'd60}, 0, 1, 0, 0);
    drain();
    check("sop_load_deferred", {8'd0, last_out}, {8'd0, 8'd50, 8'd80, 8'd60});
    send({8'd100, 8'd80, 8'd60}, 1, 1, 0, 0);
    drain();
    check("sop_load_applied", {8'd0, last_out}, {8'd0, 8'd200, 8'd80, 8'd60});

    // 4: random back-pressure over three frames
    rand_rdy = 1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 3) == 0)
          load(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 600)), 12'($urandom_range(0, 600)));
        send(24'($urandom), k == 0, k == 5, $urandom_range(0, 4) == 0, 0);
      end
    end
    drain();
    check("rand_frame_err", {31'd0, frame_err}, 0);

    // 5: framing errors
    send(24'h010203, 1, 0, 0, 0);
    send(24'h040506, 1, 0, 0, 0);
    drain();
    check("err_double_sop", {31'd0, frame_err}, 1);
    send(24'h070809, 0, 1, 0, 0);
    drain();
    check("err_sticky", {31'd0, frame_err}, 1);
    do_reset();
    check("err_cleared", {31'd0, frame_err}, 0);
    send(24'h0A0B0C, 0, 1, 0, 0);
    drain();
    check("err_eop_idle", {31'd0, frame_err}, 1);

    // 6: reset mid-frame with gains loaded
    load(512, 512, 512);
    send({8'd1, 8'd2, 8'd3}, 1, 0, 0, 0);
    send({8'd4, 8'd5, 8'd6}, 0, 0, 0, 0);
    do_reset();
    check("post_rst_err", {31'd0, frame_err}, 0);
    send({8'd50, 8'd60, 8'd70}, 1, 1, 0, 0);
    drain();
    check("post_rst_unity", {8'd0, last_out}, {8'd0, 8'd50, 8'd60, 8'd70});
    check("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
